// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser (8E1 when UART_TX_PARITY_EN is defined).
// Latency: a byte accepted into an empty FIFO while idle drops tx on the following edge; frames run back-to-back.
// Backpressure: uartWriteReady deasserts when the FIFO is full; a request while not ready is dropped and sets sticky overflow.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uartWriteReq,
    input  logic [7:0] uartWriteData,
    output logic       uartWriteReady,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_d;
    logic          push, pop;

    state_t        state, state_d;
    logic [15:0]   baud_cnt, baud_d;
    logic [2:0]    bit_cnt, bit_d;
    logic [7:0]    data_q, data_d;
    logic          tx_d;
    logic          baud_end, fifo_nonempty;

    assign uartWriteReady = (count != COUNT_FULL);
    assign push           = uartWriteReq && uartWriteReady;
    assign fifo_nonempty  = (count != '0);
    assign baud_end       = (baud_cnt == BAUD_LAST);

    always_comb begin
        count_d = count;
        case ({push, pop})
            2'b10:   count_d = count + 1'b1;
            2'b01:   count_d = count - 1'b1;
            default: count_d = count;
        endcase
    end

    // The FSM only ever sees the registered count, so a byte pushed into an empty FIFO pops one edge later.
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_cnt;
        data_d  = data_q;
        tx_d    = tx;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                tx_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    data_d  = mem[rd_ptr];
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = ^data_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_cnt + 3'd1;
                        tx_d  = data_q[bit_cnt + 3'd1];
                    end
                end else begin
                    baud_d = baud_cnt + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    baud_d = baud_cnt + 16'd1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        data_d  = mem[rd_ptr];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_cnt + 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= uartWriteData;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            data_q   <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_d;
            if (uartWriteReq && !uartWriteReady) overflow <= 1'b1;
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            data_q   <= data_d;
            tx       <= tx_d;
            busy     <= (state_d != IDLE) || (count_d != '0);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4; a line receiver decodes tx.
// Frame width follows UART_TX_PARITY_EN so the same bench covers both builds.
module tb_uart_tx_fifo;

    localparam int C = 4;
    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       req   = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       ready, tx, busy, overflow;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .uartWriteReq  (req),
        .uartWriteData (wdata),
        .uartWriteReady(ready),
        .tx            (tx),
        .busy          (busy),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  rx_q[$];
    logic [10:0] raw_q[$];
    int          start_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line receiver: samples each bit at its midpoint on falling clock edges.
    initial begin
        logic [10:0] raw;
        forever begin
            @(negedge clk);
            if (reset && !tx) begin
                raw = '0;
                start_q.push_back(cyc);
                repeat (C / 2) @(negedge clk);
                raw[0] = tx;
                for (int k = 1; k < FB; k++) begin
                    repeat (C) @(negedge clk);
                    raw[k] = tx;
                end
                raw_q.push_back(raw);
                rx_q.push_back(raw[8:1]);
            end
        end
    end

    task automatic clear_rx();
        rx_q.delete();
        raw_q.delete();
        start_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic send_one(input string tag, input logic [7:0] b, input logic [10:0] exp_raw);
        int lat = 0;
        int len = 0;
        clear_rx();
        @(negedge clk);
        req = 1'b1; wdata = b;
        @(negedge clk);
        req = 1'b0;
        while (tx && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 1);
        while (busy && len < 1000) begin
            @(negedge clk);
            len++;
        end
        check({tag, "_frame_len"}, len, FB * C);
        check({tag, "_nframes"}, rx_q.size(), 1);
        if (raw_q.size() > 0) check({tag, "_bits"}, raw_q[0], exp_raw);
    endtask

    initial begin
        logic [10:0] exp_raw;
        int t;

        #1 reset = 1'b0;
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

`ifdef UART_TX_PARITY_EN
        exp_raw = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
        exp_raw = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
        send_one("single_a5", 8'hA5, exp_raw);
        check("single_busy_after", busy, 1'b0);

        // Burst of three on consecutive cycles.
        clear_rx();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("burst_ready", ready, 1'b1);
            req = 1'b1; wdata = 8'(i + 1);
        end
        @(negedge clk);
        req = 1'b0;
        wait_idle("burst_idle");
        check("burst_nframes", rx_q.size(), 3);
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            check("burst_byte", rx_q[i], 8'(i + 1));
            check("burst_stop", raw_q[i][FB-1], 1'b1);
        end
        for (int i = 1; i < 3 && i < start_q.size(); i++)
            check("burst_gap", start_q[i] - start_q[i-1], FB * C);

        // Six back-to-back writes into a depth-4 FIFO.
        clear_rx();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("full_ready", ready, (i < 5) ? 1'b1 : 1'b0);
            req = 1'b1; wdata = 8'(8'h30 + i);
        end
        @(negedge clk);
        req = 1'b0;
        check("full_overflow_set", overflow, 1'b1);
        wait_idle("full_idle");
        check("full_overflow_sticky", overflow, 1'b1);
        check("full_nframes", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            check("full_byte", rx_q[i], 8'(8'h30 + i));

        // Reset during data bit 3 of 0x00.
        clear_rx();
        @(negedge clk);
        req = 1'b1; wdata = 8'h00;
        @(negedge clk);
        req = 1'b0;
        t = 0;
        while (tx && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rstmid_start", tx, 1'b0);
        repeat (4 * C + 1) @(negedge clk);
        check("rstmid_bit3", tx, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("rstmid_tx", tx, 1'b1);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_ready", ready, 1'b1);
        check("rstmid_overflow", overflow, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (12 * C) @(negedge clk);
        clear_rx();
        repeat (20 * C) @(negedge clk);
        check("rstmid_no_frames", rx_q.size(), 0);
        check("rstmid_tx_idle", tx, 1'b1);
        check("rstmid_busy_idle", busy, 1'b0);

`ifdef UART_TX_PARITY_EN
        exp_raw = {1'b1, 1'b1, 8'h07, 1'b0};
`else
        exp_raw = {1'b0, 1'b1, 8'h07, 1'b0};
`endif
        send_one("byte_07", 8'h07, exp_raw);

        // Ten bytes written whenever ready: pointers wrap twice.
        clear_rx();
        for (int i = 0; i < 10; i++) begin
            t = 0;
            while (!ready && t < 2000) begin
                @(negedge clk);
                t++;
            end
            check("wrap_ready", ready, 1'b1);
            req = 1'b1; wdata = 8'(8'h10 + i);
            @(negedge clk);
            req = 1'b0;
        end
        wait_idle("wrap_idle");
        check("wrap_nframes", rx_q.size(), 10);
        for (int i = 0; i < 10 && i < rx_q.size(); i++)
            check("wrap_byte", rx_q[i], 8'(8'h10 + i));
        check("wrap_overflow", overflow, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
